// File: rtl/alu_uart_interface_pkg.sv
// Shared ALU definitions: opcode encodings, opcode width and the
// front-end FSM state encoding. The ALU and the UART front-end both use it.
package alu_uart_interface_pkg;

  localparam int OPW = 6;

  localparam logic [OPW-1:0] OP_ADD = 6'b100000;
  localparam logic [OPW-1:0] OP_SUB = 6'b100010;
  localparam logic [OPW-1:0] OP_AND = 6'b100100;
  localparam logic [OPW-1:0] OP_OR  = 6'b100101;
  localparam logic [OPW-1:0] OP_XOR = 6'b100110;
  localparam logic [OPW-1:0] OP_SRA = 6'b000011;
  localparam logic [OPW-1:0] OP_SRL = 6'b000010;
  localparam logic [OPW-1:0] OP_NOR = 6'b100111;

  typedef enum logic [2:0] {
    ST_A       = 3'd0,
    ST_B       = 3'd1,
    ST_OP      = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_t;

endpackage

// File: rtl/alu_uart_interface_timeout.sv
// Inter-byte idle counter. While enabled it counts cycles since the last
// byte; expired pulses in the cycle the count sits at TIMEOUT-1 with no byte
// arriving. TIMEOUT=0 keeps the counter at zero and never expires.
module interbyte_timeout #(
  parameter int TIMEOUT = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX  = (TIMEOUT > 0) ? CW'(TIMEOUT) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry: last idle cycle reached and no byte arriving this cycle
  always_comb begin
    expired = 1'b0;
    if ((TIMEOUT != 0) && enable && !clear && (cnt_q == CNT_LAST))
      expired = 1'b1;
  end

  // Next count: clear on byte, idle state or expiry; otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if ((TIMEOUT == 0) || !enable || clear || expired)
      cnt_d = '0;
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + CW'(1);
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/alu_uart_interface.sv
// UART-to-ALU front-end: gathers operand A, operand B and opcode bytes,
// presents them to the combinational ALU from registers, then sends the
// one-byte result to the UART transmitter and waits for it to finish.
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int nbits   = 8,
  parameter int TIMEOUT = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [nbits-1:0] rx_data,
  input  logic             rx_done,
  input  logic             tx_done,
  input  logic [nbits-1:0] alu_R,
  output logic [nbits-1:0] tx_data,
  output logic             tx_start,
  output logic [nbits-1:0] alu_A,
  output logic [nbits-1:0] alu_B,
  output logic [5:0]       alu_Op,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [nbits-1:0] alu_a_q, alu_a_d;
  logic [nbits-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [nbits-1:0] tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             tmo_enable;
  logic             tmo_expired;

  // Idle timer only runs while a frame is partially received
  assign tmo_enable = (state_q == ST_B) || (state_q == ST_OP);

  interbyte_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (tmo_enable),
    .clear  (rx_done),
    .expired(tmo_expired)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_A;
    else        state_q <= state_d;
  end

  // Next-state: a received byte always wins over a simultaneous timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_A:       if (rx_done) state_d = ST_B;
      ST_B:       if (rx_done) state_d = ST_OP;
                  else if (tmo_expired) state_d = ST_A;
      ST_OP:      if (rx_done) state_d = ST_SEND;
                  else if (tmo_expired) state_d = ST_A;
      ST_SEND:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: if (tx_done) state_d = ST_A;
      default:    state_d = ST_A;
    endcase
  end

  // Outputs: operand/opcode capture, result capture with start pulse, busy flag
  always_comb begin
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy       = (state_q == ST_SEND) || (state_q == ST_WAIT_TX);
    case (state_q)
      ST_A:    if (rx_done) alu_a_d = rx_data;
      ST_B:    if (rx_done) alu_b_d = rx_data;
      ST_OP:   if (rx_done) alu_op_d = rx_data[OPW-1:0];
      ST_SEND: begin
        // alu_R has had a full cycle to settle from the registered operands
        tx_data_d  = alu_R;
        tx_start_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign alu_A    = alu_a_q;
  assign alu_B    = alu_b_q;
  assign alu_Op   = alu_op_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: two instances (TIMEOUT=16 and TIMEOUT=0),
// each with a behavioural ALU on alu_R. Table vectors, hand-written corner
// sequences and random frames are checked against expected bytes.
module tb_alu_uart_interface;
  import alu_uart_interface_pkg::*;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] r;
    logic [7:0] gap;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data  [2];
  logic       rx_done  [2];
  logic       tx_done  [2];
  logic [7:0] alu_R    [2];
  logic [7:0] tx_data  [2];
  logic       tx_start [2];
  logic [7:0] alu_A    [2];
  logic [7:0] alu_B    [2];
  logic [5:0] alu_Op   [2];
  logic       busy     [2];

  int n_pass = 0;
  int n_total = 0;
  int starts[2] = '{0, 0};
  int exp_starts[2] = '{0, 0};

  always #5 clk = ~clk;

  // Behavioural ALU, written from the opcode definitions
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRA:  return $unsigned($signed(a) >>> b[2:0]);
      OP_SRL:  return a >> b[2:0];
      default: return 8'h00;
    endcase
  endfunction

  assign alu_R[0] = alu_ref(alu_A[0], alu_B[0], alu_Op[0]);
  assign alu_R[1] = alu_ref(alu_A[1], alu_B[1], alu_Op[1]);

  alu_uart_interface #(.nbits(8), .TIMEOUT(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data[0]), .rx_done(rx_done[0]),
    .tx_done(tx_done[0]), .alu_R(alu_R[0]), .tx_data(tx_data[0]),
    .tx_start(tx_start[0]), .alu_A(alu_A[0]), .alu_B(alu_B[0]),
    .alu_Op(alu_Op[0]), .busy(busy[0])
  );

  alu_uart_interface #(.nbits(8), .TIMEOUT(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data[1]), .rx_done(rx_done[1]),
    .tx_done(tx_done[1]), .alu_R(alu_R[1]), .tx_data(tx_data[1]),
    .tx_start(tx_start[1]), .alu_A(alu_A[1]), .alu_B(alu_B[1]),
    .alu_Op(alu_Op[1]), .busy(busy[1])
  );

  // Count cycles with tx_start high on each instance
  always @(posedge clk) begin
    if (tx_start[0]) starts[0] <= starts[0] + 1;
    if (tx_start[1]) starts[1] <= starts[1] + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at a negedge; rx_done is high for exactly one rising edge
  task automatic send_byte(input int d, input logic [7:0] v);
    rx_data[d] = v;
    rx_done[d] = 1'b1;
    @(negedge clk);
    rx_done[d] = 1'b0;
    rx_data[d] = 8'($urandom);
  endtask

  // Sends a frame and checks the result appears exactly two edges after the opcode
  task automatic frame_start(input int d, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] r,
                             input int gap, input string tag);
    send_byte(d, a);
    repeat (gap) @(negedge clk);
    send_byte(d, b);
    repeat (gap) @(negedge clk);
    send_byte(d, op);
    chk({tag, ".busy_send"}, busy[d], 1);
    chk({tag, ".no_early_start"}, tx_start[d], 0);
    @(negedge clk);
    chk({tag, ".tx_start"}, tx_start[d], 1);
    chk({tag, ".tx_data"}, tx_data[d], r);
    chk({tag, ".alu_A"}, alu_A[d], a);
    chk({tag, ".alu_B"}, alu_B[d], b);
    chk({tag, ".alu_Op"}, alu_Op[d], op & 8'h3F);
    exp_starts[d]++;
    $display("frame dut%0d %s: A=%02h B=%02h Op=%02h -> tx_data=%02h (expect %02h)",
             d, tag, a, b, op, tx_data[d], r);
  endtask

  // Completes transmission with tx_done one cycle after the tx_start pulse
  task automatic frame_done(input int d, input string tag);
    @(negedge clk);
    chk({tag, ".start_pulse_end"}, tx_start[d], 0);
    chk({tag, ".busy_wait"}, busy[d], 1);
    tx_done[d] = 1'b1;
    @(negedge clk);
    tx_done[d] = 1'b0;
    chk({tag, ".idle"}, busy[d], 0);
  endtask

  task automatic chk_reset_outputs(input int d, input string tag);
    chk({tag, ".tx_data"}, tx_data[d], 0);
    chk({tag, ".tx_start"}, tx_start[d], 0);
    chk({tag, ".alu_A"}, alu_A[d], 0);
    chk({tag, ".alu_B"}, alu_B[d], 0);
    chk({tag, ".alu_Op"}, alu_Op[d], 0);
    chk({tag, ".busy"}, busy[d], 0);
    $display("reset check dut%0d %s done", d, tag);
  endtask

  initial begin
    vec_t tbl[8];
    logic [7:0] ops[8];
    logic [7:0] ra, rb, rop;

    tbl[0] = '{a: 8'h05, b: 8'h03, op: 8'h20, r: 8'h08, gap: 8'd0};
    tbl[1] = '{a: 8'h03, b: 8'h05, op: 8'h22, r: 8'hFE, gap: 8'd0};
    tbl[2] = '{a: 8'hF0, b: 8'h0F, op: 8'hE7, r: 8'h00, gap: 8'd0};
    tbl[3] = '{a: 8'h01, b: 8'h01, op: 8'h24, r: 8'h01, gap: 8'd0};
    tbl[4] = '{a: 8'h04, b: 8'h05, op: 8'h20, r: 8'h09, gap: 8'd15};
    tbl[5] = '{a: 8'hC3, b: 8'h3C, op: 8'h25, r: 8'hFF, gap: 8'd3};
    tbl[6] = '{a: 8'h80, b: 8'h02, op: 8'h03, r: 8'hE0, gap: 8'd0};
    tbl[7] = '{a: 8'h80, b: 8'h02, op: 8'h02, r: 8'h20, gap: 8'd1};
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rx_data[d] = 8'h00;
      rx_done[d] = 1'b0;
      tx_done[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs(0, "por0");
    chk_reset_outputs(1, "por1");
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, back-to-back frames
    for (int i = 0; i < 8; i++) begin
      frame_start(0, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].r, int'(tbl[i].gap),
                  $sformatf("vec%0d", i));
      frame_done(0, $sformatf("vec%0d", i));
    end

    // Timeout: byte A then exactly one cycle too many idle, frame restarts
    send_byte(0, 8'h11);
    repeat (16) @(negedge clk);
    frame_start(0, 8'h22, 8'h33, 8'h20, 8'h55, 0, "timeout");
    frame_done(0, "timeout");

    // TIMEOUT=0: long gaps never restart the frame; 0x33 is an unknown opcode
    frame_start(1, 8'h11, 8'h22, 8'h33, 8'h00, 1000, "no_timeout");
    frame_done(1, "no_timeout");

    // Bytes during ST_WAIT_TX are dropped, including one coincident with tx_done
    frame_start(0, 8'h02, 8'h03, 8'h20, 8'h05, 0, "drop_pre");
    rx_data[0] = 8'h77;
    rx_done[0] = 1'b1;
    @(negedge clk);
    rx_done[0] = 1'b0;
    chk("drop.tx_start", tx_start[0], 0);
    chk("drop.busy", busy[0], 1);
    rx_data[0] = 8'h77;
    rx_done[0] = 1'b1;
    tx_done[0] = 1'b1;
    @(negedge clk);
    rx_done[0] = 1'b0;
    tx_done[0] = 1'b0;
    chk("drop.idle", busy[0], 0);
    chk("drop.alu_A_held", alu_A[0], 8'h02);
    frame_start(0, 8'h01, 8'h01, 8'h24, 8'h01, 0, "drop_post");
    frame_done(0, "drop_post");

    // Reset after the B byte
    send_byte(0, 8'h09);
    send_byte(0, 8'h0A);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs(0, "rst_after_b");
    rst_n = 1'b1;
    frame_start(0, 8'h06, 8'h07, 8'h26, 8'h01, 0, "post_rst_b");
    frame_done(0, "post_rst_b");

    // Reset during ST_WAIT_TX
    frame_start(0, 8'h10, 8'h20, 8'h20, 8'h30, 0, "pre_rst_wait");
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs(0, "rst_wait");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wait.no_start", tx_start[0], 0);
    frame_start(0, 8'h07, 8'h09, 8'h22, 8'hFE, 0, "post_rst_wait");
    frame_done(0, "post_rst_wait");

    // Random back-to-back frames against the ALU reference
    for (int i = 0; i < 20; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 8'($urandom);
      frame_start(0, ra, rb, rop, alu_ref(ra, rb, rop[5:0]), 0, $sformatf("rnd%0d", i));
      frame_done(0, $sformatf("rnd%0d", i));
    end

    repeat (2) @(negedge clk);
    chk("start_count.dut0", starts[0], exp_starts[0]);
    chk("start_count.dut1", starts[1], exp_starts[1]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
